// File: rtl/stopwatch_counter_core.sv
// -----------------------------------------------------------------------------
// stopwatch_counter_core
//
// Four-digit BCD stopwatch datapath counting 00.00 .. 99.99 seconds
// (tens of seconds, seconds, tenths, hundredths).
//
// A prescaler divides clk100_i down to the hundredths tick rate while the
// stopwatch is RUNNING.  Each tick advances a ripple BCD cascade.  While
// STOPPED the digits can be edited one at a time (no carry between digits)
// or cleared.  The running flag is exported so the upstream digit-edit
// state machine can gate its editing.
//
// Parameters:
//   CLK_FREQ_HZ   input clock frequency in Hz
//   TICK_HZ       hundredths tick rate in Hz  (DIV = CLK_FREQ_HZ/TICK_HZ >= 2)
//
// Ports:
//   clk100_i          in   system clock
//   rst_i             in   asynchronous, active-high reset
//   start_stop_i      in   single-cycle pulse, toggles RUNNING/STOPPED
//   clear_i           in   single-cycle pulse, zeroes digits (STOPPED only)
//   edit_sel_i[2:0]   in   selected digit: 1=hund 2=tenths 3=sec 4=ten, else none
//   increm_i          in   single-cycle pulse, increments selected digit (STOPPED only)
//   device_running_o  out  1 while counting
//   hund_o[3:0]       out  BCD hundredths
//   tenths_o[3:0]     out  BCD tenths
//   sec_o[3:0]        out  BCD seconds
//   ten_o[3:0]        out  BCD tens of seconds
//   wrap_o            out  one-cycle pulse when the count rolls 99.99 -> 00.00
// -----------------------------------------------------------------------------
module stopwatch_counter_core #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 100
) (
    input  logic       clk100_i,
    input  logic       rst_i,
    input  logic       start_stop_i,
    input  logic       clear_i,
    input  logic [2:0] edit_sel_i,
    input  logic       increm_i,
    output logic       device_running_o,
    output logic [3:0] hund_o,
    output logic [3:0] tenths_o,
    output logic [3:0] sec_o,
    output logic [3:0] ten_o,
    output logic       wrap_o
);

    localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("stopwatch_counter_core: CLK_FREQ_HZ/TICK_HZ must be at least 2");
    end

    localparam logic [2:0] SEL_HUND   = 3'd1;
    localparam logic [2:0] SEL_TENTHS = 3'd2;
    localparam logic [2:0] SEL_SEC    = 3'd3;
    localparam logic [2:0] SEL_TEN    = 3'd4;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    hund_q, hund_d;
    logic [3:0]    tenths_q, tenths_d;
    logic [3:0]    sec_q, sec_d;
    logic [3:0]    ten_q, ten_d;
    logic          wrap_q, wrap_d;

    logic          running;
    logic          tick;
    logic          carry_hund;
    logic          carry_tenths;
    logic          carry_sec;
    logic          carry_ten;

    // Any value of 9 or above counts as "at max": it carries and wraps to 0,
    // so a corrupted digit self-heals on its next increment.
    function automatic logic digit_at_max(input logic [3:0] d);
        return (d >= 4'd9);
    endfunction

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return digit_at_max(d) ? 4'd0 : (d + 4'd1);
    endfunction

    assign running = (state_q == ST_RUNNING);
    assign tick    = running && (presc_q == PRESC_MAX);

    // ------------------------------------------------------------------
    // Run/stop state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_stop_i) begin
            if (state_q == ST_STOPPED) begin
                state_d = ST_RUNNING;
            end else begin
                state_d = ST_STOPPED;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler: free-runs only while RUNNING and holds while STOPPED so a
    // stop/start pair keeps the partial tick.  A clear restarts the phase.
    // ------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        if (running) begin
            if (tick) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else if (clear_i) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit update: BCD cascade on tick while RUNNING; clear/edit while
    // STOPPED, with clear taking priority over an edit in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        hund_d       = hund_q;
        tenths_d     = tenths_q;
        sec_d        = sec_q;
        ten_d        = ten_q;
        wrap_d       = 1'b0;
        carry_hund   = 1'b0;
        carry_tenths = 1'b0;
        carry_sec    = 1'b0;
        carry_ten    = 1'b0;

        if (running) begin
            if (tick) begin
                hund_d     = digit_inc(hund_q);
                carry_hund = digit_at_max(hund_q);
                if (carry_hund) begin
                    tenths_d     = digit_inc(tenths_q);
                    carry_tenths = digit_at_max(tenths_q);
                end
                if (carry_tenths) begin
                    sec_d     = digit_inc(sec_q);
                    carry_sec = digit_at_max(sec_q);
                end
                if (carry_sec) begin
                    ten_d     = digit_inc(ten_q);
                    carry_ten = digit_at_max(ten_q);
                end
                wrap_d = carry_ten;
            end
        end else if (clear_i) begin
            hund_d   = '0;
            tenths_d = '0;
            sec_d    = '0;
            ten_d    = '0;
        end else if (increm_i) begin
            case (edit_sel_i)
                SEL_HUND:   hund_d   = digit_inc(hund_q);
                SEL_TENTHS: tenths_d = digit_inc(tenths_q);
                SEL_SEC:    sec_d    = digit_inc(sec_q);
                SEL_TEN:    ten_d    = digit_inc(ten_q);
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            hund_q   <= '0;
            tenths_q <= '0;
            sec_q    <= '0;
            ten_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            hund_q   <= hund_d;
            tenths_q <= tenths_d;
            sec_q    <= sec_d;
            ten_q    <= ten_d;
            wrap_q   <= wrap_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign device_running_o = running;
    assign hund_o           = hund_q;
    assign tenths_o         = tenths_q;
    assign sec_o            = sec_q;
    assign ten_o            = ten_q;
    assign wrap_o           = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter_core
//
// Bench for stopwatch_counter_core with DIV = 1000/100 = 10.  A behavioural
// model (count kept as a 0..9999 integer) produces an expected output word
// for every driven cycle; it is queued at drive time and popped after the
// clock edge.  A constant vector table and hand-written sequences add
// fixed-value checks for edits, simultaneous events, tick latency, prescaler
// hold, wrap and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter_core;

    logic       clk;
    logic       rst;
    logic       start_stop;
    logic       clear;
    logic [2:0] edit_sel;
    logic       increm;
    logic       running;
    logic [3:0] hund;
    logic [3:0] tenths;
    logic [3:0] sec;
    logic [3:0] ten;
    logic       wrap;

    stopwatch_counter_core #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (100)
    ) dut (
        .clk100_i         (clk),
        .rst_i            (rst),
        .start_stop_i     (start_stop),
        .clear_i          (clear),
        .edit_sel_i       (edit_sel),
        .increm_i         (increm),
        .device_running_o (running),
        .hund_o           (hund),
        .tenths_o         (tenths),
        .sec_o            (sec),
        .ten_o            (ten),
        .wrap_o           (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word layout: {running, ten, sec, tenths, hund, wrap}
    typedef struct {
        logic        ss;
        logic        clr;
        logic [2:0]  sel;
        logic        inc;
        logic [17:0] exp;
    } vec_t;

    int unsigned checks;
    int unsigned errors;
    int unsigned wrap_seen;
    logic [17:0] exp_q[$];
    logic [17:0] last_out;

    // Model state
    bit m_run;
    int m_presc;
    int m_val;
    bit m_wrap;

    function automatic logic [17:0] mk(input logic r, input int t, input int s,
                                       input int th, input int h, input logic w);
        return {r, 4'(t), 4'(s), 4'(th), 4'(h), w};
    endfunction

    function automatic logic [17:0] model_word();
        return mk(m_run, (m_val / 1000) % 10, (m_val / 100) % 10,
                  (m_val / 10) % 10, m_val % 10, m_wrap);
    endfunction

    function automatic logic [17:0] dut_word();
        return {running, ten, sec, tenths, hund, wrap};
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_presc = 0;
        m_val   = 0;
        m_wrap  = 1'b0;
    endtask

    task automatic model_step(input logic ss, input logic clr,
                              input logic [2:0] sel, input logic inc);
        int p;
        int d;
        m_wrap = 1'b0;
        if (!m_run) begin
            if (clr) begin
                m_val   = 0;
                m_presc = 0;
            end else if (inc && sel >= 3'd1 && sel <= 3'd4) begin
                p = (sel == 3'd1) ? 1 : (sel == 3'd2) ? 10 : (sel == 3'd3) ? 100 : 1000;
                d = (m_val / p) % 10;
                m_val = m_val - d * p + ((d + 1) % 10) * p;
            end
            if (ss) m_run = 1'b1;
        end else begin
            if (m_presc == 9) begin
                m_presc = 0;
                if (m_val == 9999) m_wrap = 1'b1;
                m_val = (m_val + 1) % 10000;
            end else begin
                m_presc++;
            end
            if (ss) m_run = 1'b0;
        end
    endtask

    // One clock cycle: drive, predict, clock, compare against the queue.
    task automatic step(input logic ss, input logic clr,
                        input logic [2:0] sel, input logic inc);
        logic [17:0] e;
        start_stop = ss;
        clear      = clr;
        edit_sel   = sel;
        increm     = inc;
        model_step(ss, clr, sel, inc);
        exp_q.push_back(model_word());
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        edit_sel   = 3'd0;
        increm     = 1'b0;
        last_out = dut_word();
        if (wrap) wrap_seen++;
        e = exp_q.pop_front();
        checks++;
        if (last_out !== e) begin
            errors++;
            $display("FAIL cycle_sb @%0t: got 0x%05h expected 0x%05h", $time, last_out, e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic pulses(input logic [2:0] sel, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, sel, 1'b1);
    endtask

    vec_t vecs[15];

    initial begin
        checks     = 0;
        errors     = 0;
        wrap_seen  = 0;
        rst        = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        edit_sel   = 3'd0;
        increm     = 1'b0;
        model_reset();

        // Table: tenths edits 1..9,0 with no carry; invalid selects;
        // simultaneous edit+start; stop; clear+edit.
        for (int k = 0; k < 10; k++) begin
            vecs[k] = '{1'b0, 1'b0, 3'd2, 1'b1, mk(1'b0, 0, 0, (k + 1) % 10, 0, 1'b0)};
        end
        vecs[10] = '{1'b0, 1'b0, 3'd0, 1'b1, mk(1'b0, 0, 0, 0, 0, 1'b0)};
        vecs[11] = '{1'b0, 1'b0, 3'd5, 1'b1, mk(1'b0, 0, 0, 0, 0, 1'b0)};
        vecs[12] = '{1'b1, 1'b0, 3'd1, 1'b1, mk(1'b1, 0, 0, 0, 1, 1'b0)};
        vecs[13] = '{1'b1, 1'b0, 3'd0, 1'b0, mk(1'b0, 0, 0, 0, 1, 1'b0)};
        vecs[14] = '{1'b0, 1'b1, 3'd1, 1'b1, mk(1'b0, 0, 0, 0, 0, 1'b0)};

        #3;
        chk("reset_state", int'(dut_word()), 0);
        #4;
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].ss, vecs[i].clr, vecs[i].sel, vecs[i].inc);
            chk($sformatf("vec%0d", i), int'(last_out), int'(vecs[i].exp));
        end

        // First tick latency and steady rate; edits/clear ignored while running.
        step(1'b1, 1'b0, 3'd0, 1'b0);
        chk("start_running", int'(running), 1);
        idle(9);
        chk("hund_before_tick", int'(hund), 0);
        idle(1);
        chk("hund_first_tick", int'(hund), 1);
        for (int i = 0; i < 90; i++) begin
            step(1'b0, (i == 30), (i == 45) ? 3'd4 : 3'd1, (i == 20 || i == 45));
        end
        chk("run_100_cycles", int'(last_out), int'(mk(1'b1, 0, 0, 1, 0, 1'b0)));

        // Stop at prescaler count 4, hold, restart: tick 5 cycles later.
        idle(4);
        step(1'b1, 1'b0, 3'd0, 1'b0);
        chk("stopped", int'(running), 0);
        idle(3);
        step(1'b1, 1'b0, 3'd0, 1'b0);
        idle(4);
        chk("resume_before_tick", int'(last_out), int'(mk(1'b1, 0, 0, 1, 0, 1'b0)));
        idle(1);
        chk("resume_tick", int'(last_out), int'(mk(1'b1, 0, 0, 1, 1, 1'b0)));

        // Preload 99.98 and run through the wrap.
        step(1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'd0, 1'b0);
        pulses(3'd4, 9);
        pulses(3'd3, 9);
        pulses(3'd2, 9);
        pulses(3'd1, 8);
        chk("preload_9998", int'(last_out), int'(mk(1'b0, 9, 9, 9, 8, 1'b0)));
        step(1'b1, 1'b0, 3'd0, 1'b0);
        wrap_seen = 0;
        idle(10);
        chk("at_9999", int'(last_out), int'(mk(1'b1, 9, 9, 9, 9, 1'b0)));
        idle(10);
        chk("wrap_to_0000", int'(last_out), int'(mk(1'b1, 0, 0, 0, 0, 1'b1)));
        idle(1);
        chk("wrap_one_cycle", int'(wrap), 0);
        chk("wrap_count", int'(wrap_seen), 1);

        // Preload 37.41, run to 37.42, then asynchronous reset between edges.
        step(1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'd0, 1'b0);
        pulses(3'd4, 3);
        pulses(3'd3, 7);
        pulses(3'd2, 4);
        pulses(3'd1, 1);
        step(1'b1, 1'b0, 3'd0, 1'b0);
        idle(10);
        chk("at_3742", int'(last_out), int'(mk(1'b1, 3, 7, 4, 2, 1'b0)));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", int'(dut_word()), 0);
        model_reset();
        #2;
        rst = 1'b0;
        idle(12);
        chk("no_count_after_reset", int'(last_out), 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
